pipelined_lane_alu: RTL

//   Parametrised, pipelined successor to the 16-bit four-op ALU. It supports AND,
//   NOT, full-width ADD and per-lane signed saturating ADD across LANES packed lanes.
//   Two register stages with valid/ready handshakes on both sides; one op/cycle.

---
 rtl/pipelined_lane_alu.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/pipelined_lane_alu.sv
// Two-stage pipelined ALU with AND / NOT / ADD / per-lane signed saturating ADD,
// valid/ready handshakes on both sides and a sticky saturation-event counter.
module pipelined_lane_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LANES = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [LANES-1:0] out_ovf,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             cnt_clr
);

  localparam int unsigned LW = WIDTH / LANES;

  typedef enum logic [1:0] {
    OP_AND = 2'b00,
    OP_NOT = 2'b01,
    OP_ADD = 2'b10,
    OP_SAT = 2'b11
  } op_e;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  op_e              r_s1_op;

  logic             r_s2_valid;
  logic [WIDTH-1:0] r_s2_res;
  logic [LANES-1:0] r_s2_ovf;
  logic             r_s2_sat;

  logic [CNT_W-1:0] r_cnt;

  logic             w_s2_load;
  logic             w_xfer;
  logic             w_s1_load;
  logic             w_cnt_inc;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_res;
  logic [LANES-1:0] w_ovf;
  logic [LW-1:0]    w_la;
  logic [LW-1:0]    w_lb;
  logic [LW-1:0]    w_ls;

  assign w_s2_load = !r_s2_valid || out_ready;
  assign w_xfer    = r_s1_valid && w_s2_load;
  assign w_s1_load = !r_s1_valid || w_xfer;
  assign in_ready  = w_s1_load;

  assign out_valid = r_s2_valid;
  assign out_res   = r_s2_res;
  assign out_ovf   = r_s2_ovf;
  assign sat_cnt   = r_cnt;

  assign w_cnt_inc = r_s2_valid && out_ready && r_s2_sat && (|r_s2_ovf);

  always_comb begin
    w_res = '0;
    w_ovf = '0;
    w_sum = r_s1_a + r_s1_b;
    w_la  = '0;
    w_lb  = '0;
    w_ls  = '0;
    case (r_s1_op)
      OP_AND: w_res = r_s1_a & r_s1_b;
      OP_NOT: w_res = ~r_s1_b;
      OP_ADD: begin
        w_res = w_sum;
        w_ovf[LANES-1] = (r_s1_a[WIDTH-1] == r_s1_b[WIDTH-1]) &&
                         (w_sum[WIDTH-1] != r_s1_a[WIDTH-1]);
      end
      OP_SAT: begin
        // Each lane is summed in its own LW-bit adder so carries cannot cross lanes
        for (int unsigned i = 0; i < LANES; i++) begin
          w_la = r_s1_a[i*LW +: LW];
          w_lb = r_s1_b[i*LW +: LW];
          w_ls = w_la + w_lb;
          if ((w_la[LW-1] == w_lb[LW-1]) && (w_ls[LW-1] != w_la[LW-1])) begin
            w_ovf[i] = 1'b1;
            w_res[i*LW +: LW] = w_la[LW-1] ? {1'b1, {(LW-1){1'b0}}}
                                           : {1'b0, {(LW-1){1'b1}}};
          end else begin
            w_res[i*LW +: LW] = w_ls;
          end
        end
      end
      default: w_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_op    <= OP_AND;
    end else if (w_s1_load) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_a  <= in_a;
        r_s1_b  <= in_b;
        r_s1_op <= op_e'(in_op);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s2_valid <= 1'b0;
      r_s2_res   <= '0;
      r_s2_ovf   <= '0;
      r_s2_sat   <= 1'b0;
    end else if (w_s2_load) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_res <= w_res;
        r_s2_ovf <= w_ovf;
        r_s2_sat <= (r_s1_op == OP_SAT);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (cnt_clr) begin
      r_cnt <= '0;
    end else if (w_cnt_inc && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

endmodule
